// File: rtl/sdram_arb_pkg.sv
// Shared types, default widths and pointer-advance helper for the SDRAM port arbiter.
package sdram_arb_pkg;

    localparam int unsigned DEF_ADDR_W = 24;
    localparam int unsigned DEF_LEN_W  = 10;

    // Working width for pointer arithmetic; must be >= ADDR_W and >= LEN_W.
    localparam int unsigned PTR_CALC_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_XFER = 2'd2,
        ST_DONE = 2'd3
    } arb_state_t;

    // Advance a window pointer by len, wrapping to min when the next burst would
    // not fit; a window narrower than len always wraps.
    function automatic logic [PTR_CALC_W-1:0] next_ptr(
        input logic [PTR_CALC_W-1:0] ptr,
        input logic [PTR_CALC_W-1:0] min_addr,
        input logic [PTR_CALC_W-1:0] max_addr,
        input logic [PTR_CALC_W-1:0] len
    );
        logic [PTR_CALC_W-1:0] result;
        if (len > max_addr) begin
            result = min_addr;
        end else if (ptr < (max_addr - len)) begin
            result = ptr + len;
        end else begin
            result = min_addr;
        end
        return result;
    endfunction

endpackage

// File: rtl/sdram_port_arbiter_if.sv
// Request/ack bus between the port arbiter and the sdram_controller.
interface sdram_port_arbiter_if #(
    parameter int unsigned ADDR_W = 24,
    parameter int unsigned LEN_W  = 10
) ();

    logic              sdram_wr_req;
    logic              sdram_wr_ack;
    logic [ADDR_W-1:0] sdram_wr_addr;
    logic              sdram_rd_req;
    logic              sdram_rd_ack;
    logic [ADDR_W-1:0] sdram_rd_addr;
    logic [LEN_W-1:0]  sdram_burst_len;

    // Arbiter side: issues requests, receives acks.
    modport master (
        output sdram_wr_req,
        output sdram_wr_addr,
        output sdram_rd_req,
        output sdram_rd_addr,
        output sdram_burst_len,
        input  sdram_wr_ack,
        input  sdram_rd_ack
    );

    // Controller side: receives requests, returns acks.
    modport slave (
        input  sdram_wr_req,
        input  sdram_wr_addr,
        input  sdram_rd_req,
        input  sdram_rd_addr,
        input  sdram_burst_len,
        output sdram_wr_ack,
        output sdram_rd_ack
    );

endinterface

// File: rtl/sdram_addr_gen.sv
// Per-channel wrapping address pointer: reset/load to min, advance on burst completion.
module sdram_addr_gen
    import sdram_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned LEN_W  = DEF_LEN_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] min_addr,
    input  logic [ADDR_W-1:0] max_addr,
    input  logic [LEN_W-1:0]  len,
    input  logic              load,
    input  logic              advance,
    output logic [ADDR_W-1:0] ptr
);

    // Pointer register; load has priority over advance.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= min_addr;
        end else if (load) begin
            ptr <= min_addr;
        end else if (advance) begin
            ptr <= ADDR_W'(next_ptr(PTR_CALC_W'(ptr), PTR_CALC_W'(min_addr),
                                    PTR_CALC_W'(max_addr), PTR_CALC_W'(len)));
        end
    end

endmodule

// File: rtl/sdram_port_arbiter.sv
// N-channel round-robin burst arbiter in front of a single sdram_controller.
// Optional build macro SDRAM_ARB_PRIO0_EN: channel 0 wins whenever eligible and
// the round-robin pointer only arbitrates among channels 1..NUM_CH-1.
module sdram_port_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int unsigned NUM_CH = 2,
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned LEN_W  = DEF_LEN_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     init_done,
    input  logic [NUM_CH-1:0]        ch_req,
    input  logic [NUM_CH-1:0]        ch_dir,
    input  logic [NUM_CH*ADDR_W-1:0] ch_min_addr,
    input  logic [NUM_CH*ADDR_W-1:0] ch_max_addr,
    input  logic [NUM_CH*LEN_W-1:0]  ch_len,
    input  logic [NUM_CH-1:0]        ch_load,
    output logic [NUM_CH-1:0]        ch_grant,
    output logic [NUM_CH-1:0]        ch_done,
    sdram_port_arbiter_if.master     sdram_bus,
    output logic                     busy
);

    localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    arb_state_t        state;
    logic [CH_W-1:0]   rr_ptr;
    logic [CH_W-1:0]   cur_ch;
    logic              cur_dir;
    logic [LEN_W-1:0]  cur_len;
    logic              load_seen;

    logic [NUM_CH-1:0] eligible;
    logic [NUM_CH-1:0] rr_pool;
    logic [NUM_CH-1:0] advance;
    logic              pick_found;
    logic [CH_W-1:0]   pick_ch;
    logic [CH_W-1:0]   rr_next;
    logic              ack_match;

    logic [LEN_W-1:0]  len_arr [NUM_CH];
    logic [ADDR_W-1:0] ptr_arr [NUM_CH];

    // Per-channel eligibility and address pointer.
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        assign len_arr[i]  = ch_len[i*LEN_W +: LEN_W];
        assign eligible[i] = init_done & ch_req[i] & ~ch_load[i] & (len_arr[i] != '0);

        sdram_addr_gen #(
            .ADDR_W (ADDR_W),
            .LEN_W  (LEN_W)
        ) u_addr_gen (
            .clk      (clk),
            .rst      (rst),
            .min_addr (ch_min_addr[i*ADDR_W +: ADDR_W]),
            .max_addr (ch_max_addr[i*ADDR_W +: ADDR_W]),
            .len      (cur_len),
            .load     (ch_load[i]),
            .advance  (advance[i]),
            .ptr      (ptr_arr[i])
        );
    end

    // Winner selection: first eligible channel scanning upward from the RR pointer.
    always_comb begin
        int unsigned idx;
        pick_found = 1'b0;
        pick_ch    = '0;
        rr_pool    = eligible;
`ifdef SDRAM_ARB_PRIO0_EN
        rr_pool[0] = 1'b0;
`endif
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            idx = 32'(rr_ptr) + k;
            if (idx >= NUM_CH) begin
                idx = idx - NUM_CH;
            end
            if (!pick_found && rr_pool[CH_W'(idx)]) begin
                pick_found = 1'b1;
                pick_ch    = CH_W'(idx);
            end
        end
`ifdef SDRAM_ARB_PRIO0_EN
        if (eligible[0]) begin
            pick_found = 1'b1;
            pick_ch    = '0;
        end
`endif
    end

    // RR pointer value after a grant to pick_ch.
    always_comb begin
        rr_next = pick_ch + CH_W'(1);
        if ((32'(pick_ch) + 32'd1) >= NUM_CH) begin
            rr_next = '0;
        end
    end

    // Ack of the latched direction only; the other direction is ignored.
    always_comb begin
        ack_match = cur_dir ? sdram_bus.sdram_wr_ack : sdram_bus.sdram_rd_ack;
    end

    // Pointer advance on burst completion unless the channel was reloaded mid-burst.
    always_comb begin
        advance = '0;
        if ((state == ST_DONE) && !load_seen) begin
            advance[cur_ch] = 1'b1;
        end
    end

    // Arbiter FSM with registered request, grant and done outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state                     <= ST_IDLE;
            rr_ptr                    <= '0;
            cur_ch                    <= '0;
            cur_dir                   <= 1'b0;
            cur_len                   <= '0;
            load_seen                 <= 1'b0;
            ch_grant                  <= '0;
            ch_done                   <= '0;
            busy                      <= 1'b0;
            sdram_bus.sdram_wr_req    <= 1'b0;
            sdram_bus.sdram_rd_req    <= 1'b0;
            sdram_bus.sdram_wr_addr   <= '0;
            sdram_bus.sdram_rd_addr   <= '0;
            sdram_bus.sdram_burst_len <= '0;
        end else begin
            ch_grant <= '0;
            ch_done  <= '0;
            case (state)
                ST_IDLE: begin
                    if (pick_found) begin
                        cur_ch    <= pick_ch;
                        cur_dir   <= ch_dir[pick_ch];
                        cur_len   <= len_arr[pick_ch];
                        load_seen <= 1'b0;
                        ch_grant  <= NUM_CH'(1) << pick_ch;
                        busy      <= 1'b1;
                        sdram_bus.sdram_burst_len <= len_arr[pick_ch];
                        if (ch_dir[pick_ch]) begin
                            sdram_bus.sdram_wr_req  <= 1'b1;
                            sdram_bus.sdram_wr_addr <= ptr_arr[pick_ch];
                        end else begin
                            sdram_bus.sdram_rd_req  <= 1'b1;
                            sdram_bus.sdram_rd_addr <= ptr_arr[pick_ch];
                        end
`ifdef SDRAM_ARB_PRIO0_EN
                        if (pick_ch != '0) begin
                            rr_ptr <= rr_next;
                        end
`else
                        rr_ptr <= rr_next;
`endif
                        state <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (ch_load[cur_ch]) begin
                        load_seen <= 1'b1;
                    end
                    if (ack_match) begin
                        sdram_bus.sdram_wr_req <= 1'b0;
                        sdram_bus.sdram_rd_req <= 1'b0;
                        state                  <= ST_XFER;
                    end
                end
                ST_XFER: begin
                    if (ch_load[cur_ch]) begin
                        load_seen <= 1'b1;
                    end
                    if (!ack_match) begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    ch_done <= NUM_CH'(1) << cur_ch;
                    busy    <= 1'b0;
                    state   <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Self-checking bench for sdram_port_arbiter: directed scenarios plus a randomized run,
// all compared cycle by cycle against a transaction-level reference model.
module tb_sdram_port_arbiter;

    localparam int NCH = 3;
    localparam int AW  = 24;
    localparam int LW  = 10;

    logic clk = 1'b0;
    logic rst;
    logic init_done;
    logic [NCH-1:0]    ch_req;
    logic [NCH-1:0]    ch_dir;
    logic [NCH*AW-1:0] ch_min_addr;
    logic [NCH*AW-1:0] ch_max_addr;
    logic [NCH*LW-1:0] ch_len;
    logic [NCH-1:0]    ch_load;
    logic [NCH-1:0]    ch_grant;
    logic [NCH-1:0]    ch_done;
    logic              busy;

    sdram_port_arbiter_if #(.ADDR_W(AW), .LEN_W(LW)) bus ();

    sdram_port_arbiter #(
        .NUM_CH (NCH),
        .ADDR_W (AW),
        .LEN_W  (LW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .init_done   (init_done),
        .ch_req      (ch_req),
        .ch_dir      (ch_dir),
        .ch_min_addr (ch_min_addr),
        .ch_max_addr (ch_max_addr),
        .ch_len      (ch_len),
        .ch_load     (ch_load),
        .ch_grant    (ch_grant),
        .ch_done     (ch_done),
        .sdram_bus   (bus),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;

    // Reference model: one burst record plus per-channel pointers.
    int          m_phase;   // 0 idle, 1 request outstanding, 2 transferring, 3 completing
    int          m_ch;
    logic        m_dir;
    int unsigned m_len;
    bit          m_cancel;
    int          m_rr;
    int unsigned m_ptr [NCH];
    logic [NCH-1:0] e_grant, e_done;
    logic           e_wr_req, e_rd_req, e_busy;
    logic [AW-1:0]  e_wr_addr, e_rd_addr;
    logic [LW-1:0]  e_len;

    // Controller emulation and event log.
    int ack_left = 0;
    int ack_wait = -1;
    int ack_dur  = 0;
    bit ack_noise = 1'b0;
    int gq_ch[$];
    int unsigned gq_addr[$];
    int n_done = 0;

    function automatic int unsigned c_min(input int i);
        return 32'(ch_min_addr[i*AW +: AW]);
    endfunction
    function automatic int unsigned c_max(input int i);
        return 32'(ch_max_addr[i*AW +: AW]);
    endfunction
    function automatic int unsigned c_len(input int i);
        return 32'(ch_len[i*LW +: LW]);
    endfunction
    function automatic bit elig(input int i);
        return init_done && ch_req[i] && !ch_load[i] && (c_len(i) != 0);
    endfunction
    function automatic int unsigned mnext(input int unsigned p, input int unsigned mn,
                                          input int unsigned mx, input int unsigned ln);
        if (ln > mx) return mn;          // window narrower than a burst
        if (p < mx - ln) return p + ln;
        return mn;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        int c;
        bit was_active;
        if (rst) begin
            for (int i = 0; i < NCH; i++) m_ptr[i] = c_min(i);
            m_rr = 0; m_phase = 0; m_ch = 0; m_dir = 1'b0; m_len = 0; m_cancel = 1'b0;
            e_grant = '0; e_done = '0; e_wr_req = 1'b0; e_rd_req = 1'b0; e_busy = 1'b0;
            e_wr_addr = '0; e_rd_addr = '0; e_len = '0;
            return;
        end
        e_grant = '0;
        e_done  = '0;
        was_active = (m_phase == 1) || (m_phase == 2);
        case (m_phase)
            0: begin
                c = -1;
`ifdef SDRAM_ARB_PRIO0_EN
                if (elig(0)) c = 0;
`endif
                for (int k = 0; k < NCH; k++) begin
                    int i;
                    i = (m_rr + k) % NCH;
`ifdef SDRAM_ARB_PRIO0_EN
                    if (i != 0 && c < 0 && elig(i)) c = i;
`else
                    if (c < 0 && elig(i)) c = i;
`endif
                end
                if (c >= 0) begin
                    m_ch = c; m_dir = ch_dir[c]; m_len = c_len(c); m_cancel = 1'b0;
                    e_grant[c] = 1'b1;
                    e_len = LW'(m_len);
                    if (m_dir) begin e_wr_req = 1'b1; e_wr_addr = AW'(m_ptr[c]); end
                    else       begin e_rd_req = 1'b1; e_rd_addr = AW'(m_ptr[c]); end
`ifdef SDRAM_ARB_PRIO0_EN
                    if (c != 0) m_rr = (c + 1) % NCH;
`else
                    m_rr = (c + 1) % NCH;
`endif
                    e_busy = 1'b1;
                    m_phase = 1;
                end
            end
            1: if ((m_dir && bus.sdram_wr_ack) || (!m_dir && bus.sdram_rd_ack)) begin
                e_wr_req = 1'b0; e_rd_req = 1'b0; m_phase = 2;
            end
            2: if (!((m_dir && bus.sdram_wr_ack) || (!m_dir && bus.sdram_rd_ack))) m_phase = 3;
            default: begin
                e_done[m_ch] = 1'b1;
                if (!m_cancel) m_ptr[m_ch] = mnext(m_ptr[m_ch], c_min(m_ch), c_max(m_ch), m_len);
                e_busy = 1'b0;
                m_phase = 0;
            end
        endcase
        for (int i = 0; i < NCH; i++) begin
            if (ch_load[i]) begin
                m_ptr[i] = c_min(i);
                if (was_active && i == m_ch) m_cancel = 1'b1;
            end
        end
    endtask

    task automatic compare_outputs();
        check("grant",  64'(ch_grant), 64'(e_grant));
        check("done",   64'(ch_done),  64'(e_done));
        check("wr_req", 64'(bus.sdram_wr_req), 64'(e_wr_req));
        check("rd_req", 64'(bus.sdram_rd_req), 64'(e_rd_req));
        check("busy",   64'(busy), 64'(e_busy));
        if (e_wr_req) check("wr_addr", 64'(bus.sdram_wr_addr), 64'(e_wr_addr));
        if (e_rd_req) check("rd_addr", 64'(bus.sdram_rd_addr), 64'(e_rd_addr));
        if (e_wr_req || e_rd_req) check("burst_len", 64'(bus.sdram_burst_len), 64'(e_len));
    endtask

    task automatic log_events();
        for (int i = 0; i < NCH; i++) begin
            if (ch_grant[i]) begin
                gq_ch.push_back(i);
                gq_addr.push_back(bus.sdram_wr_req ? 32'(bus.sdram_wr_addr) : 32'(bus.sdram_rd_addr));
            end
            if (ch_done[i]) n_done++;
        end
    endtask

    task automatic drive_acks();
        if (rst) begin
            bus.sdram_wr_ack = 1'b0; bus.sdram_rd_ack = 1'b0; ack_left = 0; ack_wait = -1;
        end else if (ack_left > 0) begin
            ack_left--;
            if (ack_left == 0) begin bus.sdram_wr_ack = 1'b0; bus.sdram_rd_ack = 1'b0; end
        end else if (bus.sdram_wr_req || bus.sdram_rd_req) begin
            if (ack_wait < 0) ack_wait = (ack_dur > 0) ? 0 : int'($urandom_range(0, 3));
            if (ack_wait == 0) begin
                ack_wait = -1;
                bus.sdram_wr_ack = bus.sdram_wr_req;
                bus.sdram_rd_ack = bus.sdram_rd_req;
                if (ack_noise && $urandom_range(0, 2) == 0) begin
                    bus.sdram_wr_ack = 1'b1; bus.sdram_rd_ack = 1'b1;
                end
                ack_left = (ack_dur > 0) ? ack_dur : int'($urandom_range(1, 6));
            end else begin
                ack_wait--;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_outputs();
        log_events();
        drive_acks();
    endtask

    task automatic set_ch(input int i, input bit dir, input int unsigned mn,
                          input int unsigned mx, input int unsigned ln);
        ch_dir[i] = dir;
        ch_min_addr[i*AW +: AW] = AW'(mn);
        ch_max_addr[i*AW +: AW] = AW'(mx);
        ch_len[i*LW +: LW] = LW'(ln);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        gq_ch.delete(); gq_addr.delete(); n_done = 0;
    endtask

    task automatic wait_grants(input int n, input int budget, input string name);
        int c = 0;
        while (gq_ch.size() < n && c < budget) begin tick(); c++; end
        if (gq_ch.size() < n) begin
            compared++; mismatched++;
            $display("FAIL %s: got %0d grants expected %0d within %0d cycles", name, gq_ch.size(), n, budget);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_ch [6];
        int unsigned exp_ad [6];
        int unsigned t1_ad [5];
        int c;
        rst = 1'b1; init_done = 1'b1;
        ch_req = '0; ch_dir = '0; ch_load = '0;
        ch_min_addr = '0; ch_max_addr = '0; ch_len = '0;
        bus.sdram_wr_ack = 1'b0; bus.sdram_rd_ack = 1'b0;

        // Single write channel walking a 1K window in 256-word bursts.
        set_ch(0, 1'b1, 32'h0, 32'h3FF, 256);
        set_ch(1, 1'b0, 32'h0, 32'h3FF, 256);
        set_ch(2, 1'b0, 32'h0, 32'h3FF, 256);
        ack_dur = 256; ack_noise = 1'b0;
        do_reset();
        ch_req = 3'b001;
        wait_grants(5, 2000, "t1_grants");
        t1_ad = '{32'h000, 32'h100, 32'h200, 32'h300, 32'h000};
        for (int i = 0; i < 5 && i < gq_ch.size(); i++) begin
            check("t1_ch", 64'(gq_ch[i]), 64'd0);
            check("t1_addr", 64'(gq_addr[i]), 64'(t1_ad[i]));
        end
        check("t1_done_count", 64'(n_done), 64'd4);

        // Write ch0 and read ch1 requesting continuously.
        ch_req = '0;
        set_ch(0, 1'b1, 32'h0,    32'hFF,   32'h10);
        set_ch(1, 1'b0, 32'h1000, 32'h10FF, 32'h20);
        ack_dur = 0; ack_noise = 1'b1;
        do_reset();
        ch_req = 3'b011;
`ifdef SDRAM_ARB_PRIO0_EN
        exp_ch = '{0, 0, 0, 0, 0, 0};
        exp_ad = '{32'h00, 32'h10, 32'h20, 32'h30, 32'h40, 32'h50};
`else
        exp_ch = '{0, 1, 0, 1, 0, 1};
        exp_ad = '{32'h0, 32'h1000, 32'h10, 32'h1020, 32'h20, 32'h1040};
`endif
        wait_grants(6, 300, "t2_grants");
        for (int i = 0; i < 6 && i < gq_ch.size(); i++) begin
            check("t2_ch", 64'(gq_ch[i]), 64'(exp_ch[i]));
            check("t2_addr", 64'(gq_addr[i]), 64'(exp_ad[i]));
        end

        // Reload of ch0 while its third burst is transferring.
        ch_req = '0;
        set_ch(0, 1'b1, 32'h0, 32'h3FF, 32'h100);
        ack_dur = 20; ack_noise = 1'b0;
        do_reset();
        ch_req = 3'b001;
        wait_grants(3, 300, "t3_grants");
        c = 0;
        while (!(bus.sdram_wr_ack && !bus.sdram_wr_req) && c < 100) begin tick(); c++; end
        if (c >= 100) begin
            compared++; mismatched++;
            $display("FAIL t3_xfer: got no transfer phase expected one within 100 cycles");
        end
        ch_load = 3'b001;
        tick();
        ch_load = '0;
        wait_grants(4, 300, "t3_after_load");
        if (gq_ch.size() >= 4) begin
            check("t3_addr_before", 64'(gq_addr[2]), 64'h200);
            check("t3_addr_reload", 64'(gq_addr[3]), 64'h000);
        end

        // No grants until init completes, then ch0 immediately.
        set_ch(1, 1'b0, 32'h1000, 32'h10FF, 32'h20);
        set_ch(2, 1'b1, 32'h2000, 32'h20FF, 32'h8);
        init_done = 1'b0; ack_dur = 0;
        do_reset();
        ch_req = 3'b111;
        for (int i = 0; i < 100; i++) tick();
        check("t4_no_grant", 64'(gq_ch.size()), 64'd0);
        init_done = 1'b1;
        tick();
        check("t4_grant_count", 64'(gq_ch.size()), 64'd1);
        if (gq_ch.size() > 0) check("t4_grant_ch", 64'(gq_ch[0]), 64'd0);

        // Zero-length channel is never granted.
        ch_req = '0;
        set_ch(1, 1'b0, 32'h1000, 32'h10FF, 32'h0);
        do_reset();
        ch_req = 3'b011;
        for (int i = 0; i < 150; i++) tick();
        c = 0;
        foreach (gq_ch[i]) if (gq_ch[i] != 0) c++;
        check("t5_non_ch0_grants", 64'(c), 64'd0);
        if (gq_ch.size() < 5) begin
            compared++; mismatched++;
            $display("FAIL t5_ch0_grants: got %0d expected at least 5", gq_ch.size());
        end

`ifdef SDRAM_ARB_PRIO0_EN
        // Priority channel starves the others; without it ch1/ch2 alternate.
        ch_req = '0;
        set_ch(1, 1'b0, 32'h1000, 32'h10FF, 32'h20);
        do_reset();
        ch_req = 3'b111;
        wait_grants(4, 200, "t6_prio_grants");
        foreach (gq_ch[i]) check("t6_prio_ch", 64'(gq_ch[i]), 64'd0);
        ch_req = 3'b110;
        gq_ch.delete(); gq_addr.delete();
        wait_grants(4, 200, "t6_rr_grants");
        exp_ch = '{1, 2, 1, 2, 0, 0};
        for (int i = 0; i < 4 && i < gq_ch.size(); i++) check("t6_rr_ch", 64'(gq_ch[i]), 64'(exp_ch[i]));
`endif

        // Randomized traffic with loads, init drops and narrow windows.
        ch_req = '0;
        for (int i = 0; i < NCH; i++) begin
            int unsigned mn;
            mn = $urandom_range(0, 4000);
            set_ch(i, 1'($urandom_range(0, 1)), mn, mn + $urandom_range(0, 300), $urandom_range(0, 80));
        end
        ack_dur = 0; ack_noise = 1'b1;
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < NCH; i++) begin
                ch_req[i]  = ($urandom_range(0, 9) < 8);
                ch_load[i] = ($urandom_range(0, 39) == 0);
            end
            init_done = ($urandom_range(0, 19) != 0);
            tick();
        end
        ch_load = '0; ch_req = '0;
        for (int i = 0; i < 30; i++) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/sdram_port_arbiter.md
Name: sdram_port_arbiter

Overview:
N-channel burst arbiter that is the parametrised successor of the single write / single read SDRAM FIFO control path. It serves NUM_CH independent channels, each either a read or a write stream with its own wrapping address window and burst length. It sits between per-channel FIFO front-ends and the single sdram_controller write/read request/ack interface. It adds round-robin arbitration, per-channel done pulses and an optional fixed-priority channel.

Parameters:
NUM_CH, 2, number of client channels (1..8)
ADDR_W, 24, SDRAM word address width
LEN_W, 10, burst length width

Ports:
clk  in  1  controller clock (same clock as sdram_controller)
rst  in  1  synchronous, active-high reset
init_done  in  1  SDRAM initialisation complete
ch_req  in  NUM_CH  channel has a full burst ready (write) or burst space free (read); level
ch_dir  in  NUM_CH  1 = write channel, 0 = read channel; static between loads
ch_min_addr  in  NUM_CH*ADDR_W  per-channel window start, channel i at [i*ADDR_W +: ADDR_W]
ch_max_addr  in  NUM_CH*ADDR_W  per-channel window end
ch_len  in  NUM_CH*LEN_W  per-channel burst length in words
ch_load  in  NUM_CH  pulse: reset channel address pointer to its min
ch_grant  out  NUM_CH  one-hot, 1-cycle pulse when a channel's burst is issued
ch_done  out  NUM_CH  one-hot, 1-cycle pulse when that burst completes
sdram_wr_req  out  1  write request to controller
sdram_wr_ack  in  1  controller write ack, high for burst duration
sdram_wr_addr  out  ADDR_W  write start address
sdram_rd_req  out  1  read request to controller
sdram_rd_ack  in  1  controller read ack, high for burst duration
sdram_rd_addr  out  ADDR_W  read start address
sdram_burst_len  out  LEN_W  burst length of the active grant
busy  out  1  high whenever FSM is not IDLE

Behaviour:
- Reset (rst=1 at a clk edge): FSM=IDLE; all outputs 0; RR pointer=0; every channel pointer <= its ch_min_addr.
- Eligible channel i: ch_req[i]=1, ch_len[i]!=0, ch_load[i]=0 this cycle, init_done=1.
- FSM states: IDLE, REQ, XFER, DONE.
- IDLE: if any channel is eligible, pick the first eligible channel scanning from RR pointer upward, modulo NUM_CH. Latch ch, dir, pointer, len. Pulse ch_grant[ch]. Set RR pointer = ch+1 mod NUM_CH. Go to REQ. sdram_*_req rises on the same edge.
- REQ: hold wr_req (dir=1) or rd_req (dir=0), plus addr and burst_len, stable. The matching ack sampled high -> drop req on the next edge and go to XFER. The opposite-direction ack is ignored.
- XFER: wait for matching ack = 0, i.e. its falling edge. Then go to DONE.
- DONE: pulse ch_done[ch] and update the channel pointer: if ptr < max - len then ptr + len, else ptr = min (wrap). Go to IDLE. Minimum grant-to-grant spacing is 1 idle cycle.
- Address and length arithmetic is unsigned in ADDR_W bits. len is zero-extended. max - len underflow, i.e. a window smaller than len, always wraps to min.
- ch_load[i] in any state: pointer[i] <= min[i]. If i is in flight, the burst completes normally. In DONE, load wins over the increment.
- init_done falling mid-burst: the in-flight burst completes; no new grants are issued.
- ch_req dropping after grant: ignored; the burst completes.
- Simultaneous wr_ack and rd_ack: only the latched direction is used.
- At most one sdram_*_req is high at any time; req is never high while busy=0.

Optional Feature:
SDRAM_ARB_PRIO0_EN
- Defined: channel 0, when eligible, always wins in IDLE. The RR pointer is updated only by grants to channels 1..NUM_CH-1 and arbitrates among them.
- Undefined: pure round-robin over all channels, as above.

Decomposition:
- Package sdram_arb_pkg: FSM state enum (IDLE/REQ/XFER/DONE), default ADDR_W/LEN_W constants, a function computing next pointer with wrap.
- Sub-module sdram_addr_gen: one per channel via generate. Holds the pointer and handles reset, load and advance-on-done. The arbiter FSM stays in the top.

Test Plan:
- Single write ch0, min=0, max=0x3FF, len=256, ack high 256 cycles: wr_addr = 0x000, 0x100, 0x200, 0x300, then back to 0x000; one grant and one done pulse each.
- NUM_CH=2, ch0 write and ch1 read both requesting continuously: grants alternate 0,1,0,1. rd_addr and wr_addr advance independently by their own len. wr_req and rd_req are never simultaneously high.
- ch_load[0] pulsed during XFER at ptr 0x200: the burst finishes, ch_done pulses, and the next ch0 grant uses min=0x000, not 0x300.
- init_done=0 with ch_req=all ones: no grant for 100 cycles. Raise init_done: a grant to ch0 follows within 1 cycle.
- ch_len[1]=0 with ch_req[1]=1: ch1 is never granted and ch0 is served back-to-back.
- SDRAM_ARB_PRIO0_EN defined, 3 channels all requesting: sequence 0,0,0...; drop ch_req[0] and the sequence becomes 1,2,1,2.
